valu_vx_sequencer: RTL
======================

# valu_vx_sequencer

Element sequencer and ALU for the vector-scalar (.vx/.vi) instruction forms. It consumes `dataA_64`, the scalar register value or sign-extended immediate chosen by the operand-A selector, and broadcasts it against each element of vs2. Elements are read from the vector register file one at a time, the selected operation is applied at the current SEW, and results are written to vd through a ready/valid write port. The block sits between the operand-A selector and the vector register file writeback.

## Interface
Parameters:
- `VLMAX`, 64: maximum element count; index width is log2(VLMAX).
- `ELEN`, 64: element storage word width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  operation request, accepted only in IDLE.
- `valu_op`  in  3  operation: 000 add, 001 sub (vs2−A), 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 sra.
- `sew`  in  2  element width: 00=8, 01=16, 10=32, 11=64.
- `vl`  in  7  element count, 0..VLMAX; values above VLMAX clamp to VLMAX.
- `dataA_64`  in  64  scalar/immediate operand from the operand-A selector.
- `vs2_rd_en`  out  1  vs2 element read request.
- `vs2_rd_idx`  out  6  vs2 element index.
- `vs2_rd_data`  in  64  element word, valid the cycle after `vs2_rd_en`; the element is in the low SEW bits.
- `vd_wr_en`  out  1  result valid.
- `vd_wr_idx`  out  6  destination element index.
- `vd_wr_data`  out  64  result, zero-extended above SEW.
- `vd_wr_ready`  in  1  register file accepts the write when `vd_wr_en && vd_wr_ready`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, READ, EXEC, WRITE, DONE.
- **IDLE, on `start`:**
  - Latch `valu_op`, `sew`, clamped `vl`, and `dataA_64` truncated to SEW bits.
  - Clear the element counter.
  - Go to DONE if latched vl==0, else READ.
- **Ignored inputs:** `start` outside IDLE is ignored. Input changes after the latch have no effect.
- **READ:** `vs2_rd_en`=1, `vs2_rd_idx`=counter. Always → EXEC.
- **EXEC:**
  - B = `vs2_rd_data`[SEW-1:0].
  - Compute the result at SEW width and register it into `vd_wr_data` with upper bits zero.
  - → WRITE.
- **Arithmetic rules:**
  - add/sub wrap modulo 2^SEW.
  - Shift amount = A[log2(SEW)-1:0], and only those bits are used.
  - sra replicates bit SEW-1 of B.
- **WRITE:**
  - `vd_wr_en`=1, `vd_wr_idx`=counter. Data and index are held stable until accepted.
  - On accept: if counter==vl-1 → DONE; else increment counter → READ.
  - Without accept: stay in WRITE.
- **DONE:** `done`=1 for one cycle → IDLE.
- **Reset (any time, including mid-operation):**
  - All registers and outputs go to 0; state = IDLE.
  - A pending write is dropped. No `done` is issued for the aborted operation.

## Timing
- Reset values: `vs2_rd_en`, `vs2_rd_idx`, `vd_wr_en`, `vd_wr_idx`, `vd_wr_data`, `busy`, `done` all 0.
- All outputs are driven from registers or directly decoded from the state register. There are no combinational paths from inputs to outputs.
- Cycle numbering: `start` is sampled at edge E0, and cycle n is the cycle after edge En-1.
- Element i, with `vd_wr_ready` held high:
  - READ in cycle 3i+1.
  - EXEC in cycle 3i+2.
  - WRITE in cycle 3i+3.
- DONE falls in cycle 3·vl+1, plus one cycle for each cycle that `vd_wr_ready` was low.
- vl==0: DONE in cycle 1, with no reads and no writes.
- `start` asserted in the DONE cycle is ignored. A new `start` is accepted one cycle later, in IDLE.
- `busy` is high from cycle 1 through the DONE cycle inclusive.

## Test plan
- **add, SEW=8, wrap:** sew=00, vl=3, A=0x…FF (−1), vs2 low bytes {0x00,0x01,0x80}, ready=1 → writes idx0..2 = 0xFF, 0x00, 0x7F with upper 56 bits zero; done pulses in cycle 10.
- **sub and sra, SEW=16:**
  - sub: vl=2, A=0x0003, vs2 {0x0001,0x8000} → writes 0xFFFE, 0x7FFD.
  - sra: A=0x…0014, vs2=0x8000 → shift amount 4 (only the low 4 bits are used) → 0xF800.
- **vl=0 and clamp:**
  - vl=0 → no `vs2_rd_en`, no `vd_wr_en`; `done` in cycle 1; `busy` high for 1 cycle.
  - vl=100 → exactly 64 writes.
- **Backpressure:** sew=11, vl=2, `vd_wr_ready` low for 5 cycles on element 0 → `vd_wr_en`, idx, and data stable throughout; the element 1 read is issued only after acceptance; `done` in cycle 12.
- **Start while busy:** a second `start` with different op/vl mid-operation → ignored; results match the first operation only.
- **Reset mid-operation:** assert `rst` asynchronously (between edges) in WRITE of element 1 → outputs go to 0 immediately; no `done`; after release, a new `start` runs cleanly from index 0.

Source files
------------

// File: rtl/valu_vx_sequencer.sv
// valu_vx_sequencer
//
// Purpose:
//   Element sequencer and ALU for the vector-scalar (.vx/.vi) instruction
//   forms. A scalar or immediate operand (dataA_64) is broadcast against
//   each element of vs2. Elements are fetched one at a time from the vector
//   register file, combined with the scalar at the selected element width
//   (SEW), and written to vd through a ready/valid write port.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   start        - operation request, accepted only while idle
//   valu_op      - 000 add, 001 sub (vs2-A), 010 and, 011 or, 100 xor,
//                  101 sll, 110 srl, 111 sra
//   sew          - element width: 00=8, 01=16, 10=32, 11=64
//   vl           - element count, values above VLMAX clamp to VLMAX
//   dataA_64     - scalar / sign-extended immediate operand
//   vs2_rd_en    - vs2 element read request
//   vs2_rd_idx   - vs2 element index
//   vs2_rd_data  - vs2 element word, valid the cycle after vs2_rd_en
//   vd_wr_en     - result valid
//   vd_wr_idx    - destination element index
//   vd_wr_data   - result, zero-extended above SEW
//   vd_wr_ready  - register file accepts the write when en && ready
//   busy         - high whenever the sequencer is not idle
//   done         - one-cycle completion pulse
module valu_vx_sequencer #(
  parameter int VLMAX = 64,
  parameter int ELEN  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2:0]                 valu_op,
  input  logic [1:0]                 sew,
  input  logic [$clog2(VLMAX):0]     vl,
  input  logic [ELEN-1:0]            dataA_64,
  output logic                       vs2_rd_en,
  output logic [$clog2(VLMAX)-1:0]   vs2_rd_idx,
  input  logic [ELEN-1:0]            vs2_rd_data,
  output logic                       vd_wr_en,
  output logic [$clog2(VLMAX)-1:0]   vd_wr_idx,
  output logic [ELEN-1:0]            vd_wr_data,
  input  logic                       vd_wr_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(VLMAX);
  localparam logic [IDX_W:0] VLMAX_W = (IDX_W+1)'(VLMAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  logic [2:0]       r_state;
  logic [2:0]       r_op;
  logic [1:0]       r_sew;
  logic [IDX_W:0]   r_vl;
  logic [ELEN-1:0]  r_a;
  logic [IDX_W-1:0] r_cnt;
  logic [ELEN-1:0]  r_result;

  logic [IDX_W:0]   w_vlClamped;
  logic [ELEN-1:0]  w_inMask;
  logic [ELEN-1:0]  w_mask;
  logic [ELEN-1:0]  w_b;
  logic [ELEN-1:0]  w_bSext;
  logic [5:0]       w_shamt;
  logic [ELEN-1:0]  w_raw;
  logic [ELEN-1:0]  w_result;
  logic             w_lastElem;

  // Low-SEW-bits mask for a given width code.
  function automatic logic [ELEN-1:0] sewMask(input logic [1:0] s);
    case (s)
      2'b00:   sewMask = ELEN'(64'h0000_0000_0000_00FF);
      2'b01:   sewMask = ELEN'(64'h0000_0000_0000_FFFF);
      2'b10:   sewMask = ELEN'(64'h0000_0000_FFFF_FFFF);
      default: sewMask = {ELEN{1'b1}};
    endcase
  endfunction

  // Values above VLMAX saturate so the counter never walks past the file.
  assign w_vlClamped = (vl > VLMAX_W) ? VLMAX_W : vl;

  assign w_inMask = sewMask(sew);
  assign w_mask   = sewMask(r_sew);

  // The register file returns a full word; only the low SEW bits are the
  // element, anything above is ignored.
  assign w_b = vs2_rd_data & w_mask;

  // Sign-extended copy of B used only by sra, so the arithmetic shift
  // replicates bit SEW-1 instead of bit 63.
  always_comb begin
    w_bSext = w_b;
    case (r_sew)
      2'b00:   w_bSext = {{56{w_b[7]}},  w_b[7:0]};
      2'b01:   w_bSext = {{48{w_b[15]}}, w_b[15:0]};
      2'b10:   w_bSext = {{32{w_b[31]}}, w_b[31:0]};
      default: w_bSext = w_b;
    endcase
  end

  // Shift amount uses only log2(SEW) bits of A; the rest is discarded.
  always_comb begin
    w_shamt = r_a[5:0];
    case (r_sew)
      2'b00:   w_shamt = {3'b000, r_a[2:0]};
      2'b01:   w_shamt = {2'b00,  r_a[3:0]};
      2'b10:   w_shamt = {1'b0,   r_a[4:0]};
      default: w_shamt = r_a[5:0];
    endcase
  end

  // Operations run on full-width words and are masked back to SEW at the
  // end; that gives wrap-around for add/sub and drops bits shifted past SEW.
  always_comb begin
    w_raw = '0;
    case (r_op)
      OP_ADD:  w_raw = w_b + r_a;
      OP_SUB:  w_raw = w_b - r_a;
      OP_AND:  w_raw = w_b & r_a;
      OP_OR:   w_raw = w_b | r_a;
      OP_XOR:  w_raw = w_b ^ r_a;
      OP_SLL:  w_raw = w_b << w_shamt;
      OP_SRL:  w_raw = w_b >> w_shamt;
      OP_SRA:  w_raw = ELEN'($signed(w_bSext) >>> w_shamt);
      default: w_raw = '0;
    endcase
  end

  assign w_result = w_raw & w_mask;

  assign w_lastElem = ({1'b0, r_cnt} == (r_vl - (IDX_W+1)'(1)));

  // Main sequencer: latches the operation on start, then walks the
  // elements READ -> EXEC -> WRITE, holding WRITE until the register file
  // takes the result. Reset drops any pending write without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_sew    <= '0;
      r_vl     <= '0;
      r_a      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= valu_op;
            r_sew <= sew;
            r_vl  <= w_vlClamped;
            r_a   <= dataA_64 & w_inMask;
            r_cnt <= '0;
            r_state <= (w_vlClamped == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= w_result;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          if (vd_wr_ready) begin
            if (w_lastElem) begin
              r_state <= S_DONE;
            end else begin
              r_cnt   <= r_cnt + IDX_W'(1);
              r_state <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs come straight from registers or from state decode, so no
  // input reaches an output combinationally.
  assign vs2_rd_en  = (r_state == S_READ);
  assign vs2_rd_idx = r_cnt;
  assign vd_wr_en   = (r_state == S_WRITE);
  assign vd_wr_idx  = r_cnt;
  assign vd_wr_data = r_result;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule
